fsm_trace_fifo: RTL and testbench

- Downstream observer for the 2-bit control FSM. Samples the FSM's `state` output every clock.
- Logs each state change as a {prev,next} record into a small first-word-fall-through FIFO, drained by a valid/ready reader.
- Keeps a saturating count of completed laps (st3 -> st0) and a sticky overflow flag.
- Sits beside the FSM on the same clock/reset; used for debug readout and self-checking benches.

---
 rtl/fsm_trace_fifo.sv | 72 +++++++
 tb/tb_fsm_trace_fifo.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fsm_trace_fifo.sv
// fsm_trace_fifo: logs FSM state changes into a FWFT FIFO, counts st3->st0 laps, flags dropped records
module fsm_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [1:0]              state,
  input  logic                    clr,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [3:0]              rd_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        laps,
  output logic                    ovf
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0]    prev_q;
  logic [3:0]    mem [DEPTH];
  logic [3:0]    last_q;
  logic [3:0]    rec;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          ev;
  logic          pop;
  logic          push;
  logic          drop;
  logic          full;
  // event detection, handshake decode and head/hold readout
  always_comb begin
    rec = {prev_q, state};
    ev = state != prev_q;
    full = level == (AW+1)'(DEPTH);
    rd_valid = level != '0;
    pop = rd_valid && rd_ready;
    push = ev && (!full || pop);
    drop = ev && full && !pop;
    rd_data = rd_valid ? mem[rp] : last_q;
  end
  // record storage; only read through live pointers, so no reset
  always_ff @(posedge clk)
    if (push && !clr) mem[wp] <= rec;
  // pointers, occupancy, lap counter and sticky overflow; clr beats push/pop
  always_ff @(posedge clk or posedge res)
    if (res) begin
      prev_q <= '0;
      wp <= '0;
      rp <= '0;
      level <= '0;
      laps <= '0;
      ovf <= 1'b0;
      last_q <= '0;
    end else begin
      prev_q <= state;
      if (clr) begin
        wp <= '0;
        rp <= '0;
        level <= '0;
        laps <= '0;
        ovf <= 1'b0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop) begin
          rp <= rp + 1'b1;
          last_q <= mem[rp];
        end
        level <= level + (AW+1)'(push) - (AW+1)'(pop);
        if (drop) ovf <= 1'b1;
        if (ev && rec == 4'b1100 && laps != '1) laps <= laps + 1'b1;
      end
    end
endmodule

// File: tb/tb_fsm_trace_fifo.sv
// tb_fsm_trace_fifo: table vectors plus queue scoreboard for the FSM trace FIFO
module tb_fsm_trace_fifo;
  localparam int DEPTH = 8;
  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       clr = 1'b0;
  logic       rd_ready = 1'b0;
  logic [1:0] state = 2'd0;
  logic       rd_valid, ovf, rd_valid2, ovf2;
  logic [3:0] rd_data, rd_data2, level, level2;
  logic [7:0] laps;
  logic [1:0] laps2;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [3:0] mq[$];
  logic [1:0] mprev = 2'd0;
  int         mlaps = 0;
  int         mlaps2 = 0;
  logic       movf = 1'b0;
  typedef struct {
    logic [1:0] st;
    logic       rdy;
    int         lvl;
    int         lp;
  } vec_t;
  vec_t tbl[8];

  fsm_trace_fifo #(.DEPTH(DEPTH), .CNT_W(8)) u1 (
    .clk(clk), .res(res), .state(state), .clr(clr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .level(level), .laps(laps), .ovf(ovf)
  );
  fsm_trace_fifo #(.DEPTH(DEPTH), .CNT_W(2)) u2 (
    .clk(clk), .res(res), .state(state), .clr(clr), .rd_ready(rd_ready),
    .rd_valid(rd_valid2), .rd_data(rd_data2), .level(level2), .laps(laps2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [1:0] st, input logic rdy, input logic c);
    bit ev, pop, full;
    state = st;
    rd_ready = rdy;
    clr = c;
    #1;
    if (mq.size() != 0) chk("head", rd_data, mq[0]);
    chk("valid_pre", rd_valid, mq.size() != 0);
    ev = st != mprev;
    if (c) begin
      mq.delete();
      mlaps = 0;
      mlaps2 = 0;
      movf = 1'b0;
    end else begin
      pop = rdy && mq.size() != 0;
      full = mq.size() == DEPTH;
      if (pop) void'(mq.pop_front());
      if (ev && (!full || pop)) mq.push_back({mprev, st});
      else if (ev) movf = 1'b1;
      if (ev && {mprev, st} == 4'b1100) begin
        mlaps = mlaps < 255 ? mlaps + 1 : 255;
        mlaps2 = mlaps2 < 3 ? mlaps2 + 1 : 3;
      end
    end
    mprev = st;
    @(posedge clk);
    @(negedge clk);
    chk("level", level, mq.size());
    chk("laps", laps, mlaps);
    chk("laps2", laps2, mlaps2);
    chk("ovf", ovf, movf);
    chk("valid", rd_valid, mq.size() != 0);
    if (mq.size() != 0) chk("head_post", rd_data, mq[0]);
  endtask

  initial begin
    tbl[0] = '{2'd1, 1'b0, 1, 0};
    tbl[1] = '{2'd2, 1'b0, 2, 0};
    tbl[2] = '{2'd3, 1'b0, 3, 0};
    tbl[3] = '{2'd0, 1'b0, 4, 1};
    tbl[4] = '{2'd0, 1'b1, 3, 1};
    tbl[5] = '{2'd0, 1'b1, 2, 1};
    tbl[6] = '{2'd0, 1'b1, 1, 1};
    tbl[7] = '{2'd0, 1'b1, 0, 1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_level", level, 0);
    chk("rst_laps", laps, 0);
    chk("rst_ovf", ovf, 0);
    res = 1'b0;
    for (int i = 0; i < 10; i++) step(2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].st, tbl[i].rdy, 1'b0);
      chk("tbl_level", level, tbl[i].lvl);
      chk("tbl_laps", laps, tbl[i].lp);
    end
    chk("hold_data", rd_data, 4'hC);
    for (int i = 0; i < 9; i++) step(i % 2 == 0 ? 2'd1 : 2'd0, 1'b0, 1'b0);
    chk("full_level", level, 8);
    chk("full_ovf", ovf, 1);
    chk("full_head", rd_data, 4'h1);
    step(2'd0, 1'b1, 1'b0);
    chk("full_swap_level", level, 8);
    for (int i = 0; i < 8; i++) step(2'd0, 1'b1, 1'b0);
    step(2'd0, 1'b0, 1'b1);
    chk("clr_ovf", ovf, 0);
    for (int i = 0; i < 8; i++) step(i % 2 == 0 ? 2'd1 : 2'd0, 1'b0, 1'b0);
    step(2'd1, 1'b1, 1'b0);
    chk("swap_level", level, 8);
    chk("swap_ovf", ovf, 0);
    for (int i = 0; i < 8; i++) step(2'd1, 1'b1, 1'b0);
    step(2'd1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(2'((i + 2) % 4), 1'b1, 1'b0);
    step(2'd0, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) step(2'(i), 1'b0, 1'b0);
    chk("pre_rst_level", level, 3);
    chk("pre_rst_laps", laps, 2);
    state = 2'd0;
    #2 res = 1'b1;
    #1;
    chk("arst_valid", rd_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_laps", laps, 0);
    #1 res = 1'b0;
    mq.delete();
    mprev = 2'd0;
    mlaps = 0;
    mlaps2 = 0;
    movf = 1'b0;
    @(negedge clk);
    step(2'd1, 1'b0, 1'b0);
    chk("post_rst_rec", rd_data, 4'h1);
    for (int i = 2; i < 7; i++) step(2'(i % 4), 1'b0, 1'b0);
    step(2'd2, 1'b1, 1'b0);
    chk("pre_clr_level", level, 5);
    step(2'd3, 1'b0, 1'b1);
    chk("clr_level", level, 0);
    chk("clr_laps", laps, 0);
    step(2'd0, 1'b0, 1'b0);
    chk("after_clr_rec", rd_data, 4'hC);
    chk("after_clr_laps", laps, 1);
    for (int i = 0; i < 20; i++) step(2'((i + 1) % 4), 1'b1, 1'b0);
    chk("laps_six", laps, 6);
    chk("laps2_sat", laps2, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
